// File: rtl/segway_alert_mon_pkg.sv
// Shared types, widths and default thresholds for the segway alert monitor.
// Optional BATT_LATCH_EN (see segway_alert_mon) makes batt_low sticky until reset.
package segway_alert_pkg;

    localparam int SPD_W  = 12;
    localparam int BATT_W = 12;
    localparam int SUM_W  = 14;

    localparam logic [SPD_W-1:0]  TF_HI_DEF   = 12'd1792;
    localparam logic [SPD_W-1:0]  TF_LO_DEF   = 12'd1536;
    localparam logic [BATT_W-1:0] BATT_LO_DEF = 12'hA98;
    localparam logic [BATT_W-1:0] BATT_HI_DEF = 12'hAC0;
    localparam int                DEB_CNT_DEF = 8;

    typedef enum logic [1:0] {
        BATT_OK,
        BATT_PEND,
        BATT_LOW
    } batt_state_t;

    // The most negative code has no positive twin, so it clamps to full scale.
    function automatic logic [SPD_W-1:0] satAbs(input logic signed [SPD_W-1:0] v);
        if (!v[SPD_W-1])
            return v;
        else if (v == {1'b1, {(SPD_W-1){1'b0}}})
            return {1'b0, {(SPD_W-1){1'b1}}};
        else
            return -v;
    endfunction

endpackage

// File: rtl/segway_alert_mon_mov_avg4.sv
// Four-sample moving average with running sum, fill counter and a one-cycle
// eval pulse trailing each accepted sample; reusable for any 12-bit A2D channel.
module mov_avg4
    import segway_alert_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_smpVld,
    input  logic [BATT_W-1:0] i_sample,
    output logic [BATT_W-1:0] o_avg,
    output logic              o_full,
    output logic              o_eval
);

    logic [3:0][BATT_W-1:0] r_win;
    logic [SUM_W-1:0]       r_sum;
    logic [2:0]             r_fill;
    logic                   r_eval;

    // Slot 3 is the oldest sample; it leaves the sum as the new one enters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win  <= '0;
            r_sum  <= '0;
            r_fill <= '0;
            r_eval <= 1'b0;
        end else begin
            r_eval <= i_smpVld;
            if (i_smpVld) begin
                r_win <= {r_win[2:0], i_sample};
                r_sum <= r_sum - SUM_W'(r_win[3]) + SUM_W'(i_sample);
                if (r_fill != 3'd4)
                    r_fill <= r_fill + 3'd1;
            end
        end
    end

    assign o_avg  = r_sum[SUM_W-1:2];
    assign o_full = (r_fill == 3'd4);
    assign o_eval = r_eval;

endmodule

// File: rtl/segway_alert_mon.sv
// Overspeed and low-battery alert levels for the piezo driver, with hysteresis
// and battery debounce. Define BATT_LATCH_EN to make batt_low sticky until reset.
module segway_alert_mon
    import segway_alert_pkg::*;
#(
    parameter logic [SPD_W-1:0]  TF_HI   = TF_HI_DEF,
    parameter logic [SPD_W-1:0]  TF_LO   = TF_LO_DEF,
    parameter logic [BATT_W-1:0] BATT_LO = BATT_LO_DEF,
    parameter logic [BATT_W-1:0] BATT_HI = BATT_HI_DEF,
    parameter int                DEB_CNT = DEB_CNT_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_vld,
    input  logic [SPD_W-1:0]  lft_spd,
    input  logic [SPD_W-1:0]  rght_spd,
    input  logic [BATT_W-1:0] batt,
    output logic              too_fast,
    output logic              batt_low,
    output logic [BATT_W-1:0] batt_avg
);

    localparam logic [7:0] DEB_MAX = 8'(DEB_CNT);

    logic [SPD_W-1:0]  r_lftMag;
    logic [SPD_W-1:0]  r_rghtMag;
    logic              r_tooFast;
    logic [BATT_W-1:0] r_battAvg;
    logic              r_battLow;
    logic [7:0]        r_debCnt;
    batt_state_t       r_state;

    logic [SPD_W-1:0]  w_magMax;
    logic [BATT_W-1:0] w_avg;
    logic              w_full;
    logic              w_eval;

    mov_avg4 u_battAvg (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_smpVld (smp_vld),
        .i_sample (batt),
        .o_avg    (w_avg),
        .o_full   (w_full),
        .o_eval   (w_eval)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lftMag  <= '0;
            r_rghtMag <= '0;
        end else if (smp_vld) begin
            r_lftMag  <= satAbs(lft_spd);
            r_rghtMag <= satAbs(rght_spd);
        end
    end

    assign w_magMax = (r_lftMag > r_rghtMag) ? r_lftMag : r_rghtMag;

    // Magnitudes equal to either threshold leave too_fast where it was.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tooFast <= 1'b0;
            r_battAvg <= '0;
        end else if (w_eval) begin
            r_battAvg <= w_avg;
            if (w_magMax > TF_HI)
                r_tooFast <= 1'b1;
            else if (w_magMax < TF_LO)
                r_tooFast <= 1'b0;
        end
    end

    // Battery debounce only runs once the window holds four real samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= BATT_OK;
            r_debCnt  <= '0;
            r_battLow <= 1'b0;
        end else if (w_eval && w_full) begin
            case (r_state)
                BATT_OK: begin
                    if (w_avg < BATT_LO) begin
                        r_debCnt <= 8'd1;
                        if (DEB_MAX == 8'd1) begin
                            r_state   <= BATT_LOW;
                            r_battLow <= 1'b1;
                        end else begin
                            r_state <= BATT_PEND;
                        end
                    end
                end
                BATT_PEND: begin
                    if (w_avg < BATT_LO) begin
                        r_debCnt <= r_debCnt + 8'd1;
                        if (r_debCnt + 8'd1 >= DEB_MAX) begin
                            r_state   <= BATT_LOW;
                            r_battLow <= 1'b1;
                        end
                    end else begin
                        r_state  <= BATT_OK;
                        r_debCnt <= '0;
                    end
                end
                BATT_LOW: begin
`ifdef BATT_LATCH_EN
                    r_state <= BATT_LOW;
`else
                    if (w_avg >= BATT_HI) begin
                        r_state   <= BATT_OK;
                        r_debCnt  <= '0;
                        r_battLow <= 1'b0;
                    end
`endif
                end
                default: begin
                    r_state   <= BATT_OK;
                    r_debCnt  <= '0;
                    r_battLow <= 1'b0;
                end
            endcase
        end
    end

    assign too_fast = r_tooFast;
    assign batt_low = r_battLow;
    assign batt_avg = r_battAvg;

endmodule

// File: tb/tb_segway_alert_mon.sv
// Self-checking bench for segway_alert_mon: directed vector table, async reset
// sequence, then randomized samples against a behavioural reference model.
module tb_segway_alert_mon;

    localparam int TF_HI   = 1792;
    localparam int TF_LO   = 1536;
    localparam int BATT_LO = 'hA98;
    localparam int BATT_HI = 'hAC0;
    localparam int DEB     = 8;
`ifdef BATT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smpVld = 1'b0;
    logic [11:0] lftSpd = '0;
    logic [11:0] rghtSpd = '0;
    logic [11:0] batt = '0;
    logic        tooFast;
    logic        battLow;
    logic [11:0] battAvg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    segway_alert_mon dut (
        .clk      (clk),
        .rst      (rst),
        .smp_vld  (smpVld),
        .lft_spd  (lftSpd),
        .rght_spd (rghtSpd),
        .batt     (batt),
        .too_fast (tooFast),
        .batt_low (battLow),
        .batt_avg (battAvg)
    );

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        logic [11:0] bat;
        bit          tf;
        bit          low;
        logic [11:0] avg;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: last four battery samples, low-run length, alert levels.
    int winQ[$];
    int lowRun;
    bit mTooFast;
    bit mBattLow;
    int mAvg;

    task automatic modelReset();
        winQ.delete();
        lowRun   = 0;
        mTooFast = 1'b0;
        mBattLow = 1'b0;
        mAvg     = 0;
    endtask

    function automatic int magOf(input logic [11:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 2047) v = 2047;
        return v;
    endfunction

    task automatic modelStep(input logic [11:0] l, input logic [11:0] r, input logic [11:0] b);
        int mag;
        int sum;
        mag = (magOf(l) > magOf(r)) ? magOf(l) : magOf(r);
        if (mag > TF_HI) mTooFast = 1'b1;
        else if (mag < TF_LO) mTooFast = 1'b0;
        winQ.push_front(int'(b));
        if (winQ.size() > 4) void'(winQ.pop_back());
        sum = 0;
        foreach (winQ[i]) sum += winQ[i];
        mAvg = sum / 4;
        if (winQ.size() == 4) begin
            if (mBattLow) begin
                if (!LATCH && mAvg >= BATT_HI) begin
                    mBattLow = 1'b0;
                    lowRun   = 0;
                end
            end else if (mAvg < BATT_LO) begin
                lowRun++;
                if (lowRun >= DEB) mBattLow = 1'b1;
            end else begin
                lowRun = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input bit eTf, input bit eLow, input logic [11:0] eAvg);
        checks += 3;
        if (tooFast !== eTf) begin
            errors++;
            $display("[TB] FAIL %s too_fast: got %0b expected %0b", name, tooFast, eTf);
        end
        if (battLow !== eLow) begin
            errors++;
            $display("[TB] FAIL %s batt_low: got %0b expected %0b", name, battLow, eLow);
        end
        if (battAvg !== eAvg) begin
            errors++;
            $display("[TB] FAIL %s batt_avg: got %h expected %h", name, battAvg, eAvg);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r, input logic [11:0] b);
        smpVld  = 1'b1;
        lftSpd  = l;
        rghtSpd = r;
        batt    = b;
    endtask

    task automatic addVec(input logic [11:0] l, input logic [11:0] r, input logic [11:0] b,
                          input bit tf, input bit low, input logic [11:0] avg);
        vec_t v;
        v.lft = l; v.rght = r; v.bat = b; v.tf = tf; v.low = low; v.avg = avg;
        tbl.push_back(v);
    endtask

    // Every cycle, outputs must reflect all samples driven two or more negedges earlier.
    task automatic runRandom(input int nCyc, input int pctVld, input int bLo, input int bHi);
        bit          vq[$];
        logic [11:0] lq[$];
        logic [11:0] rq[$];
        logic [11:0] bq[$];
        logic [11:0] s[2];
        for (int k = 0; k < nCyc + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                if (vq[k-2]) modelStep(lq[k-2], rq[k-2], bq[k-2]);
                checkOutput($sformatf("rand%0d", k), mTooFast, mBattLow, 12'(mAvg));
            end
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 3))
                    0: s[j] = 12'($urandom);
                    1: s[j] = 12'($urandom_range(1500, 1830));
                    2: s[j] = 12'(-int'($urandom_range(1500, 2048)));
                    default: s[j] = 12'($urandom_range(0, 40));
                endcase
            end
            vq.push_back((k < nCyc) && ($urandom_range(1, 100) <= pctVld));
            lq.push_back(s[0]);
            rq.push_back(s[1]);
            bq.push_back(12'($urandom_range(bLo, bHi)));
            if (vq[k]) applyStimulus(lq[k], rq[k], bq[k]);
            else smpVld = 1'b0;
        end
        smpVld = 1'b0;
    endtask

    initial begin
        bit          pTf;
        bit          pLow;
        logic [11:0] pAvg;
        bit          eLow;

        addVec(12'd1800, 12'd0, 12'h900, 1, 0, 12'h240);
        addVec(12'd1600, 12'd0, 12'h900, 1, 0, 12'h480);
        addVec(12'd1535, 12'd0, 12'h900, 0, 0, 12'h6C0);
        addVec(12'h800,  12'd0, 12'h900, 1, 0, 12'h900);
        addVec(12'd0,    12'd0, 12'h900, 0, 0, 12'h900);
        addVec(12'd1792, 12'd0, 12'h900, 0, 0, 12'h900);
        addVec(12'd0,  12'h8F8, 12'h900, 1, 0, 12'h900);
        addVec(12'd1536, 12'd0, 12'h900, 1, 0, 12'h900);
        addVec(12'd0,    12'd0, 12'h900, 0, 0, 12'h900);
        addVec(12'd0,    12'd0, 12'h900, 0, 0, 12'h900);
        addVec(12'd0,    12'd0, 12'h900, 0, 1, 12'h900);
        addVec(12'd0,    12'd0, 12'hAB0, 0, 1, 12'h96C);
        addVec(12'd0,    12'd0, 12'hAB0, 0, 1, 12'h9D8);
        addVec(12'd0,    12'd0, 12'hAB0, 0, 1, 12'hA44);
        addVec(12'd0,    12'd0, 12'hAB0, 0, 1, 12'hAB0);
        addVec(12'd0,    12'd0, 12'hAC0, 0, 1, 12'hAB4);
        addVec(12'd0,    12'd0, 12'hAC0, 0, 1, 12'hAB8);
        addVec(12'd0,    12'd0, 12'hAC0, 0, 1, 12'hABC);
        addVec(12'd0,    12'd0, 12'hAC0, 0, 0, 12'hAC0);
        addVec(12'd0,    12'd0, 12'h900, 0, 0, 12'hA50);
        addVec(12'd0,    12'd0, 12'hBE0, 0, 0, 12'hA98);
        addVec(12'd0,    12'd0, 12'h900, 0, 0, 12'hA28);
        addVec(12'd0,    12'd0, 12'h900, 0, 0, 12'h9B8);
        addVec(12'd0,    12'd0, 12'h900, 0, 0, 12'h9B8);
        for (int i = 0; i < 4; i++)
            addVec(12'd0, 12'd0, 12'h900, 0, 0, 12'h900);
        addVec(12'd0,    12'd0, 12'h900, 0, 1, 12'h900);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 12'h000);

        pTf = 1'b0; pLow = 1'b0; pAvg = '0;
        for (int i = 0; i < tbl.size(); i++) begin
            eLow = LATCH ? (i >= 10) : tbl[i].low;
            @(negedge clk);
            applyStimulus(tbl[i].lft, tbl[i].rght, tbl[i].bat);
            @(negedge clk);
            smpVld = 1'b0;
            checkOutput($sformatf("vec%0d_hold", i), pTf, pLow, pAvg);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), tbl[i].tf, eLow, tbl[i].avg);
            pTf = tbl[i].tf; pLow = eLow; pAvg = tbl[i].avg;
        end

        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("asyncRst", 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            applyStimulus(12'd0, 12'd0, 12'h900);
            @(negedge clk);
            smpVld = 1'b0;
            @(negedge clk);
            modelStep(12'd0, 12'd0, 12'h900);
            checkOutput($sformatf("refill%0d", j), 1'b0, 1'b0, 12'(12'h240 * (j + 1)));
        end

        runRandom(40, 100, 'h900, 'hA90);
        runRandom(200, 60, 'hA80, 'hB00);
        runRandom(300, 50, 'h980, 'hBFF);
        runRandom(60, 100, 'hAA0, 'hBFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
